// File: rtl/gbuff_arbiter.sv
// rtl/gbuff_arbiter.sv - two-port round-robin arbiter/sequencer for a single-port global buffer BRAM
module gbuff_arbiter #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_wr,
    input  logic [1:0]           req_last,
    input  logic [ADDR_BITS-1:0] req_addr0,
    input  logic [ADDR_BITS-1:0] req_addr1,
    input  logic [DATA_BITS-1:0] req_wdata0,
    input  logic [DATA_BITS-1:0] req_wdata1,
    output logic [1:0]           rsp_valid,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 ram_en,
    output logic                 ram_wr_en,
    output logic [ADDR_BITS-1:0] ram_index,
    output logic [DATA_BITS-1:0] ram_data_in,
    input  logic [DATA_BITS-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_prio;
    logic [1:0] r_rd_pend;

    logic [1:0] w_ready;
    logic       w_gnt;
    logic       w_any;

    // Grants are masked by rst_n so every output reads 0 while reset is held.
    always_comb begin
        w_ready = 2'b00;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (&req_valid) w_ready[r_prio] = 1'b1;
                    else            w_ready = req_valid;
                end
                LOCK0:   w_ready[0] = req_valid[0];
                LOCK1:   w_ready[1] = req_valid[1];
                default: w_ready = 2'b00;
            endcase
        end
    end

    assign w_gnt       = w_ready[1];
    assign w_any       = |w_ready;
    assign req_ready   = w_ready;
    assign ram_en      = w_any;
    assign ram_wr_en   = w_any & req_wr[w_gnt];
    assign ram_index   = !w_any ? '0 : (w_gnt ? req_addr1 : req_addr0);
    assign ram_data_in = !w_any ? '0 : (w_gnt ? req_wdata1 : req_wdata0);
    assign rsp_valid   = r_rd_pend;
    assign rsp_data    = (|r_rd_pend) ? ram_data_out : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_prio    <= 1'b0;
            r_rd_pend <= 2'b00;
        end else begin
            r_rd_pend <= w_ready & ~req_wr;
            if (w_any) begin
                if (req_last[w_gnt]) begin
                    r_state <= IDLE;
                    r_prio  <= ~w_gnt;
                end else begin
                    r_state <= w_gnt ? LOCK1 : LOCK0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gbuff_arbiter.sv
// tb/tb_gbuff_arbiter.sv - self-checking bench for gbuff_arbiter with BRAM and reference model
module tb_gbuff_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_wr, req_last, rsp_valid;
    logic [11:0] req_addr0, req_addr1, ram_index;
    logic [31:0] req_wdata0, req_wdata1, rsp_data, ram_data_in, ram_data_out;
    logic        ram_en, ram_wr_en;

    int checks = 0;
    int errors = 0;

    gbuff_arbiter #(.ADDR_BITS(12), .DATA_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_last(req_last),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_en(ram_en), .ram_wr_en(ram_wr_en), .ram_index(ram_index),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // BRAM: 1-cycle read latency, data_out holds across writes.
    logic [31:0] mem [4096];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_en) mem[ram_index] <= ram_data_in;
            else           ram_data_out   <= mem[ram_index];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: lock owner (-1 none), preferred port, expected responses, shadow memory.
    int          m_lock = -1;
    int          m_prio = 0;
    int          m_g;
    logic [1:0]  m_pv = 2'b00;
    logic [31:0] m_pd = 32'h0;
    logic [31:0] shadow [4096];
    logic [1:0]  e_ready;
    logic [11:0] e_addr;
    logic [31:0] e_wdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", {30'h0, req_ready}, 32'h0);
            chk("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
            chk("rst_rsp_data", rsp_data, 32'h0);
            chk("rst_ram", {ram_en, ram_wr_en, ram_index, 18'h0}, 32'h0);
            chk("rst_ram_din", ram_data_in, 32'h0);
            m_lock = -1; m_prio = 0; m_pv = 2'b00;
        end else begin
            if (m_lock >= 0)                   m_g = req_valid[m_lock] ? m_lock : -1;
            else if (req_valid == 2'b11)       m_g = m_prio;
            else if (req_valid[0])             m_g = 0;
            else if (req_valid[1])             m_g = 1;
            else                               m_g = -1;
            e_ready = (m_g < 0) ? 2'b00 : (m_g == 0 ? 2'b01 : 2'b10);
            e_addr  = (m_g < 0) ? 12'h0 : (m_g == 0 ? req_addr0 : req_addr1);
            e_wdata = (m_g < 0) ? 32'h0 : (m_g == 0 ? req_wdata0 : req_wdata1);
            chk("ready", {30'h0, req_ready}, {30'h0, e_ready});
            chk("ram_en", {31'h0, ram_en}, {31'h0, m_g >= 0});
            chk("ram_wr_en", {31'h0, ram_wr_en}, {31'h0, (m_g >= 0) && req_wr[m_g & 1]});
            chk("ram_index", {20'h0, ram_index}, {20'h0, e_addr});
            chk("ram_data_in", ram_data_in, e_wdata);
            chk("rsp_valid", {30'h0, rsp_valid}, {30'h0, m_pv});
            if (m_pv != 2'b00) chk("rsp_data", rsp_data, m_pd);
            m_pv = 2'b00;
            if (m_g >= 0) begin
                if (req_wr[m_g]) shadow[e_addr] = e_wdata;
                else begin
                    m_pv = e_ready;
                    m_pd = shadow[e_addr];
                end
                if (req_last[m_g]) begin
                    m_lock = -1;
                    m_prio = 1 - m_g;
                end else begin
                    m_lock = m_g;
                end
            end
        end
    end

    // Drive one cycle of requests at posedge+1, return at posedge+3 for literal checks.
    task automatic drive(input logic [1:0] v, input logic [1:0] wr, input logic [1:0] last,
                         input logic [11:0] a0, input logic [11:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        @(posedge clk);
        #1;
        req_valid = v; req_wr = wr; req_last = last;
        req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
        #2;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b11, 12'h0, 12'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 32'hA000_0000 | i;
            shadow[i] = 32'hA000_0000 | i;
        end
        rst_n = 1'b0;
        req_valid = 2'b11; req_wr = 2'b00; req_last = 2'b11;
        req_addr0 = 12'h001; req_addr1 = 12'h002; req_wdata0 = 32'h0; req_wdata1 = 32'h0;
        #3;
        chk("lit_reset_ready", {30'h0, req_ready}, 32'h0);
        chk("lit_reset_ram_en", {31'h0, ram_en}, 32'h0);
        chk("lit_reset_rsp", {30'h0, rsp_valid}, 32'h0);
        chk("lit_reset_rsp_data", rsp_data, 32'h0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write then read the same address from port 0.
        drive(2'b01, 2'b01, 2'b11, 12'h010, 12'h0, 32'hDEADBEEF, 32'h0);
        chk("lit_wr_ready", {30'h0, req_ready}, 32'h1);
        chk("lit_wr_ram", {ram_en, ram_wr_en, ram_index, 18'h0}, {2'b11, 12'h010, 18'h0});
        chk("lit_wr_din", ram_data_in, 32'hDEADBEEF);
        drive(2'b01, 2'b00, 2'b11, 12'h010, 12'h0, 32'h0, 32'h0);
        chk("lit_rd_ready", {30'h0, req_ready}, 32'h1);
        chk("lit_rd_wr_en", {31'h0, ram_wr_en}, 32'h0);
        idle();
        chk("lit_rd_rsp_valid", {30'h0, rsp_valid}, 32'h1);
        chk("lit_rd_rsp_data", rsp_data, 32'hDEADBEEF);

        // Both ports reading every cycle from reset.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'b00, 2'b11, 12'h020, 12'h030, 32'h0, 32'h0);
            chk("lit_rr_ready", {30'h0, req_ready}, (k % 2) ? 32'h2 : 32'h1);
            if (k > 0) begin
                chk("lit_rr_rsp_valid", {30'h0, rsp_valid}, (k % 2) ? 32'h1 : 32'h2);
                chk("lit_rr_rsp_data", rsp_data, (k % 2) ? 32'hA000_0020 : 32'hA000_0030);
            end
        end
        idle();
        chk("lit_rr_rsp_last", {30'h0, rsp_valid}, 32'h2);
        chk("lit_rr_data_last", rsp_data, 32'hA000_0030);

        // Port 0 single makes port 1 preferred, then port 1 bursts 4 beats under contention.
        drive(2'b01, 2'b00, 2'b11, 12'h040, 12'h0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'b00, {k == 3, 1'b1}, 12'h040, 12'h100 + 12'(k), 32'h0, 32'h0);
            chk("lit_burst_ready", {30'h0, req_ready}, 32'h2);
        end
        drive(2'b11, 2'b00, 2'b11, 12'h040, 12'h200, 32'h0, 32'h0);
        chk("lit_burst_p0_after", {30'h0, req_ready}, 32'h1);
        chk("lit_burst_last_data", rsp_data, 32'hA000_0103);

        // LOCK0 with port 0 dropping valid for 3 cycles.
        drive(2'b01, 2'b01, 2'b10, 12'h050, 12'h0, 32'h1111_0000, 32'h0);
        chk("lit_lock_start", {30'h0, req_ready}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            drive(2'b10, 2'b00, 2'b11, 12'h050, 12'h060, 32'h0, 32'h0);
            chk("lit_lock_hold_ready", {30'h0, req_ready}, 32'h0);
            chk("lit_lock_hold_en", {31'h0, ram_en}, 32'h0);
        end
        drive(2'b11, 2'b01, 2'b11, 12'h051, 12'h060, 32'h2222_0000, 32'h0);
        chk("lit_lock_resume", {30'h0, req_ready}, 32'h1);
        drive(2'b10, 2'b00, 2'b11, 12'h0, 12'h051, 32'h0, 32'h0);
        chk("lit_lock_release", {30'h0, req_ready}, 32'h2);

        // Read accepted, then reset asserted before the response edge.
        drive(2'b01, 2'b00, 2'b11, 12'h060, 12'h0, 32'h0, 32'h0);
        chk("lit_prerst_ready", {30'h0, req_ready}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("lit_midrst_ready", {30'h0, req_ready}, 32'h0);
        for (int k = 0; k < 2; k++) begin
            drive(2'b11, 2'b00, 2'b11, 12'h060, 12'h061, 32'h0, 32'h0);
            chk("lit_inrst_rsp", {30'h0, rsp_valid}, 32'h0);
            chk("lit_inrst_en", {31'h0, ram_en}, 32'h0);
        end
        rst_n = 1'b1;
        #1;
        chk("lit_postrst_grant", {30'h0, req_ready}, 32'h1);

        // Read A, port 1 writes A, read A again.
        drive(2'b01, 2'b00, 2'b11, 12'h070, 12'h0, 32'h0, 32'h0);
        drive(2'b10, 2'b10, 2'b11, 12'h0, 12'h070, 32'h0, 32'h1234_5678);
        chk("lit_raw_old", rsp_data, 32'hA000_0070);
        drive(2'b01, 2'b00, 2'b11, 12'h070, 12'h0, 32'h0, 32'h0);
        idle();
        chk("lit_raw_new_valid", {30'h0, rsp_valid}, 32'h1);
        chk("lit_raw_new", rsp_data, 32'h1234_5678);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gbuff_arbiter.md
# gbuff_arbiter

Two-requester round-robin arbiter and sequencer for one single-port global buffer BRAM (1-cycle read latency, read-or-write per cycle). It sits between the BRAM and two masters, typically the DMA loader (port 0) and the PE-array operand fetcher (port 1). It grants one access per cycle, supports locked bursts, and routes each read response back to the port that issued it.

## Interface
- ADDR_BITS, 12: BRAM address width.
- DATA_BITS, 32: BRAM data width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid[1:0]  in  2  per-port request valid.
- req_ready[1:0]  out  2  per-port grant; the request is accepted when valid&ready.
- req_wr[1:0]  in  2  per-port 1 = write, 0 = read.
- req_last[1:0]  in  2  per-port last beat of a burst; 1 on single accesses.
- req_addr0, req_addr1  in  ADDR_BITS  per-port address.
- req_wdata0, req_wdata1  in  DATA_BITS  per-port write data.
- rsp_valid[1:0]  out  2  per-port read-data valid, one-cycle pulse.
- rsp_data  out  DATA_BITS  read data, shared by both ports; qualify with rsp_valid.
- ram_en  out  1  to BRAM ram_en.
- ram_wr_en  out  1  to BRAM wr_en.
- ram_index  out  ADDR_BITS  to BRAM index.
- ram_data_in  out  DATA_BITS  to BRAM data_in.
- ram_data_out  in  DATA_BITS  from BRAM data_out.

## Operation
- States:
  - IDLE: no lock.
  - LOCK0: port 0 owns the buffer.
  - LOCK1: port 1 owns the buffer.
- Priority register `prio` (1 bit) selects the preferred port in IDLE. Reset: IDLE, prio=0.
- Grant selection, combinational from current state, req_valid and prio:
  - IDLE, one port valid: that port is granted.
  - IDLE, both ports valid: port `prio` is granted.
  - LOCKn: only port n can be granted, and only when req_valid[n]=1. The other port gets ready=0.
  - At most one bit of req_ready is 1 at any time. req_ready[i]=1 implies req_valid[i]=1.
- Accepted beat from port g:
  - ram_en=1, ram_wr_en=req_wr[g], ram_index=req_addrg, ram_data_in=req_wdatag.
  - With no grant: ram_en=0, ram_wr_en=0. ram_index and ram_data_in are don't-care and are driven to 0.
- State and prio update on an accepted beat from port g:
  - req_last[g]=1: state goes to IDLE and prio becomes ~g (round-robin, the other port is preferred next).
  - req_last[g]=0: state goes to LOCKg and prio is unchanged.
  - LOCKg with req_valid[g]=0: the state holds LOCKg. The lock waits and the bus idles; the other port is never granted.
- Read return:
  - An accepted read sets registered flag rd_pend[g]. The next cycle, rsp_valid[g]=1 and rsp_data=ram_data_out (combinational pass-through).
  - Writes never produce rsp_valid.
  - Masters must sink the response; there is no response back-pressure.
- Reset assertion at any time, including mid-burst or with a read pending:
  - State returns to IDLE, prio=0, rd_pend=0.
  - All outputs go to 0 immediately; the pending response is dropped.

## Timing
- Request-to-grant: 0 cycles (combinational ready). Back-to-back accepts are allowed every cycle.
- Read latency: 1 cycle from acceptance edge to rsp_valid. Sustained throughput is 1 access per cycle.
- Reset values of all outputs: req_ready=0, rsp_valid=0, rsp_data=0, ram_en=0, ram_wr_en=0, ram_index=0, ram_data_in=0.
- Read then write to the same address in consecutive cycles: the read response carries the old data. The BRAM write does not update data_out.
- Write then read to the same address in consecutive cycles: the read returns the new data.
- rsp_valid for beat k coincides with the grant for beat k+1; the two are independent.
- rsp_data when both rsp_valid bits are 0: don't-care. It is driven 0 after reset until the first read.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to address 0x010 and reads address 0x010 on the next cycle:
  - Both beats get ready in their cycle.
  - rsp_valid=2'b01 one cycle after the read, with rsp_data=0xDEADBEEF.
- Both ports present single reads every cycle from reset:
  - Grants alternate 0,1,0,1.
  - rsp_valid alternates 01,10 with 1-cycle lag.
  - Each response carries the data stored at that port's address.
- Port 1 issues a 4-beat read burst (last on beat 4) while port 0 holds valid the whole time:
  - Port 0 ready=0 for all 4 beats.
  - Port 0 is granted the cycle after beat 4.
- Port 0 is in LOCK0 and drops valid for 3 cycles while port 1 is valid:
  - ram_en=0 and req_ready=0 on both ports for those 3 cycles.
  - The burst resumes when port 0 reasserts valid.
- Read accepted, then rst_n pulled low before the response edge:
  - rsp_valid stays 0 and all outputs are 0 during reset.
  - After release, the first contention grant goes to port 0.
- Port 0 reads address A while port 1 writes A in the next cycle:
  - Port 0 receives the pre-write value.
  - A subsequent read of A returns the port 1 data.
